axis_channel_serializer: RTL and testbench
==========================================

Name: axis_channel_serializer

Overview:
- Consumer end of the 6-output AXIS channel selector.
- Holds the latest sample of each of the six valid-only selected streams.
- Snapshots those samples on a programmable decimation tick and serializes the enabled channels into one backpressured AXIS stream (tready/tlast) for the DMA/stream writer.
- Frames are dropped and counted when the downstream cannot keep up.

Parameters:
- SAXIS_TDATA_WIDTH, 32, input channel data width.
- MAXIS_TDATA_WIDTH, 32, output data width; must be >= SAXIS_TDATA_WIDTH; narrower inputs are sign-extended.
- DECI_WIDTH, 32, width of the decimation register.

Ports:
- a_clk  in  1  clock.
- a_resetn  in  1  asynchronous active-low reset.
- S_AXIS_1_tdata .. S_AXIS_6_tdata  in  SAXIS_TDATA_WIDTH  selected channel data.
- S_AXIS_1_tvalid .. S_AXIS_6_tvalid  in  1  channel valid; there is no tready.
- enable  in  1  run; framing stops when low.
- channel_mask  in  6  bit k-1 enables channel k in a frame.
- decimation  in  DECI_WIDTH  tick period in a_clk cycles; 0 is treated as 1.
- M_AXIS_tdata  out  MAXIS_TDATA_WIDTH  serialized word.
- M_AXIS_tvalid  out  1  output valid.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tlast  out  1  last word of frame.
- busy  out  1  frame in progress (state SEND).
- overrun_count  out  16  dropped-frame counter; saturates at 0xFFFF.

Behaviour:
- Reset (a_resetn low, asynchronous):
  - Outputs: M_AXIS_tvalid=0, tlast=0, tdata=0, busy=0, overrun_count=0.
  - Internal: holding registers=0, decimation counter=0, state IDLE.
- Holding registers: hold[k] <= S_AXIS_k_tdata on any cycle with S_AXIS_k_tvalid=1, independent of enable or state.
- Decimation counter:
  - Counts while enable=1. Tick when cnt == max(decimation,1)-1, then cnt<=0.
  - enable=0 clears cnt to 0 and suppresses ticks.
- Tick in IDLE with channel_mask != 0:
  - Latch snap[k]=hold[k] (value at that edge, before any same-cycle update) and snap_mask=channel_mask.
  - Go to SEND. M_AXIS_tvalid=1 on the next cycle (latency 1 from the tick edge).
- Tick with channel_mask == 0: ignored, not an overrun.
- SEND:
  - Words are emitted in ascending channel order over the set bits of snap_mask.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - Advance on tvalid&tready. tlast=1 only on the word of the highest set bit.
  - Handshake of the tlast word: return to IDLE with tvalid=0 on the next cycle. No back-to-back frame in that same cycle; the next frame needs a new tick.
- Tick while in SEND: frame dropped, overrun_count += 1 (saturating). The current frame continues unaffected.
- channel_mask and decimation changes take effect at the next snapshot and next compare respectively; an in-flight frame uses snap_mask.
- enable deasserted mid-frame: the current frame completes normally; no new ticks.
- Single-channel mask: one word per frame, with tlast=1.
- Width: M_AXIS_tdata = sign-extended snap[k].

Optional Feature:
- Macro AXIS_CHANNEL_SERIALIZER_HEADER_EN.
- When defined:
  - Each frame is preceded by one header word: [31:16] frame_id, [15:6] zero, [5:0] snap_mask (upper bits zero when MAXIS > 32).
  - Header tlast=0.
  - frame_id is a 16-bit counter, reset 0, incremented per emitted frame and wrapping; dropped frames do not increment it.
  - Latency to the first data word is still 1 cycle to tvalid, but the first word is the header.
- When not defined: data words only; no frame_id logic.

Decomposition:
- Package axis_channel_serializer_pkg:
  - NUM_CH=6.
  - state enum {IDLE, SEND}.
  - Header field positions and widths (FRAME_ID_LSB=16, MASK_LSB=0, MASK_W=6).
  - OVR_W=16.
- Sub-module axis_ser_deci_tick: decimation counter with enable, zero-as-one rule and single-cycle tick output.
- Channel sequencing (find next set bit above the current index) is a package function.

Test Plan:
- Frame emission: decimation=4, mask=6'b000101, tready=1, hold1=0x11, hold3=0x33 → every 4 cycles two words 0x11 then 0x33; tlast only on 0x33; tvalid 1 cycle after tick.
- Backpressure: mask=6'b111111, tready toggling 1/0 → six words in order 1..6, each stable while stalled, exactly one tlast.
- Overrun: decimation=2, mask=6'b111111, tready=0 for 20 cycles → one frame pending and overrun_count increments once per later tick (9); after release, the pending frame completes intact.
- Mask and decimation corners: mask=0 for 100 cycles → no tvalid, overrun_count=0. decimation=0 → tick every cycle, same as decimation=1.
- Reset and enable mid-frame:
  - a_resetn low during word 3 → tvalid=0 and overrun_count=0 immediately, restart clean.
  - enable=0 during word 3 → remaining words sent, then no further frames.
- Header (with AXIS_CHANNEL_SERIALIZER_HEADER_EN): mask=6'b000011, 3 frames → headers 0x00000003, 0x00010003, 0x00020003, each followed by two data words.

Source files
------------

// File: rtl/axis_channel_serializer_pkg.sv
// Shared types, header layout and channel-sequencing helper for axis_channel_serializer.
package axis_channel_serializer_pkg;

    localparam int unsigned NUM_CH       = 6;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned OVR_W        = 16;
    localparam int unsigned FRAME_ID_LSB = 16;
    localparam int unsigned FRAME_ID_W   = 16;
    localparam int unsigned MASK_LSB     = 0;
    localparam int unsigned MASK_W       = 6;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } ch_sel_t;

    // Lowest set bit of mask at index >= from; found=0 when none remain.
    function automatic ch_sel_t next_ch(input logic [NUM_CH-1:0] mask,
                                        input logic [IDX_W-1:0]  from);
        ch_sel_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!r.found && (i >= 32'(from)) && mask[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_ser_deci_tick.sv
// Decimation counter: single-cycle tick every max(decimation_i,1) cycles while enabled.
module axis_ser_deci_tick
    import axis_channel_serializer_pkg::*;
#(
    parameter int unsigned DECI_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [DECI_WIDTH-1:0] decimation_i,
    output logic                  tick_o
);

    logic [DECI_WIDTH-1:0] cnt_q;
    logic [DECI_WIDTH-1:0] cnt_d;
    logic [DECI_WIDTH-1:0] last_cnt;

    always_comb begin
        last_cnt = (decimation_i == '0) ? '0 : decimation_i - DECI_WIDTH'(1);
        tick_o   = enable_i && (cnt_q == last_cnt);
        cnt_d    = cnt_q + DECI_WIDTH'(1);
        if (!enable_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_channel_serializer.sv
// Snapshots six valid-only channels on a decimation tick and serializes the enabled ones
// onto one AXIS stream. Define AXIS_CHANNEL_SERIALIZER_HEADER_EN to prefix each frame with a header word.
module axis_channel_serializer
    import axis_channel_serializer_pkg::*;
#(
    parameter int unsigned SAXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAXIS_TDATA_WIDTH = 32,
    parameter int unsigned DECI_WIDTH        = 32
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_1_tdata,
    input  logic                         S_AXIS_1_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_2_tdata,
    input  logic                         S_AXIS_2_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_3_tdata,
    input  logic                         S_AXIS_3_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_4_tdata,
    input  logic                         S_AXIS_4_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_5_tdata,
    input  logic                         S_AXIS_5_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_6_tdata,
    input  logic                         S_AXIS_6_tvalid,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            channel_mask,
    input  logic [DECI_WIDTH-1:0]        decimation,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic                         M_AXIS_tlast,
    output logic                         busy,
    output logic [OVR_W-1:0]             overrun_count
);

    logic [SAXIS_TDATA_WIDTH-1:0] in_data [NUM_CH];
    logic [NUM_CH-1:0]            in_valid;

    logic [SAXIS_TDATA_WIDTH-1:0] hold_q [NUM_CH];
    logic [SAXIS_TDATA_WIDTH-1:0] hold_d [NUM_CH];
    logic [SAXIS_TDATA_WIDTH-1:0] snap_q [NUM_CH];
    logic [SAXIS_TDATA_WIDTH-1:0] snap_d [NUM_CH];
    logic [NUM_CH-1:0]            snap_mask_q, snap_mask_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    state_e                       state_q, state_d;
    logic [OVR_W-1:0]             ovr_q, ovr_d;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
    logic                         hdr_q, hdr_d;
    logic [FRAME_ID_W-1:0]        frame_id_q, frame_id_d;
    logic [MAXIS_TDATA_WIDTH-1:0] hdr_word;
`endif

    logic    tick;
    ch_sel_t first_sel;
    ch_sel_t next_sel;

    axis_ser_deci_tick #(
        .DECI_WIDTH(DECI_WIDTH)
    ) u_deci_tick (
        .clk_i       (a_clk),
        .rst_ni      (a_resetn),
        .enable_i    (enable),
        .decimation_i(decimation),
        .tick_o      (tick)
    );

    always_comb begin
        in_data[0]  = S_AXIS_1_tdata;
        in_data[1]  = S_AXIS_2_tdata;
        in_data[2]  = S_AXIS_3_tdata;
        in_data[3]  = S_AXIS_4_tdata;
        in_data[4]  = S_AXIS_5_tdata;
        in_data[5]  = S_AXIS_6_tdata;
        in_valid    = {S_AXIS_6_tvalid, S_AXIS_5_tvalid, S_AXIS_4_tvalid,
                       S_AXIS_3_tvalid, S_AXIS_2_tvalid, S_AXIS_1_tvalid};
        first_sel   = next_ch(channel_mask, '0);
        next_sel    = next_ch(snap_mask_q, idx_q + IDX_W'(1));
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                hold_q[k] <= '0;
                snap_q[k] <= '0;
            end
            snap_mask_q <= '0;
            idx_q       <= '0;
            state_q     <= IDLE;
            ovr_q       <= '0;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
            hdr_q       <= 1'b0;
            frame_id_q  <= '0;
`endif
        end else begin
            hold_q      <= hold_d;
            snap_q      <= snap_d;
            snap_mask_q <= snap_mask_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            ovr_q       <= ovr_d;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
            hdr_q       <= hdr_d;
            frame_id_q  <= frame_id_d;
`endif
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            hold_d[k] = in_valid[k] ? in_data[k] : hold_q[k];
        end
        snap_d      = snap_q;
        snap_mask_d = snap_mask_q;
        idx_d       = idx_q;
        state_d     = state_q;
        ovr_d       = ovr_q;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
        hdr_d       = hdr_q;
        frame_id_d  = frame_id_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Snapshot takes hold_q, i.e. the value before this edge's channel update.
                if (tick && (channel_mask != '0)) begin
                    snap_d      = hold_q;
                    snap_mask_d = channel_mask;
                    idx_d       = first_sel.idx;
                    state_d     = SEND;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
                    hdr_d       = 1'b1;
`endif
                end
            end
            SEND: begin
                if (tick && (ovr_q != '1)) begin
                    ovr_d = ovr_q + OVR_W'(1);
                end
                if (M_AXIS_tready) begin
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                    end else
`endif
                    if (next_sel.found) begin
                        idx_d = next_sel.idx;
                    end else begin
                        state_d = IDLE;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
                        frame_id_d = frame_id_q + FRAME_ID_W'(1);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        M_AXIS_tvalid = (state_q == SEND);
        busy          = (state_q == SEND);
        overrun_count = ovr_q;
        M_AXIS_tdata  = '0;
        M_AXIS_tlast  = 1'b0;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
        hdr_word = '0;
        hdr_word[FRAME_ID_LSB +: FRAME_ID_W] = frame_id_q;
        hdr_word[MASK_LSB +: MASK_W]         = snap_mask_q;
`endif
        if (state_q == SEND) begin
            M_AXIS_tdata = MAXIS_TDATA_WIDTH'($signed(snap_q[idx_q]));
            M_AXIS_tlast = !next_sel.found;
`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
            if (hdr_q) begin
                M_AXIS_tdata = hdr_word;
                M_AXIS_tlast = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axis_channel_serializer.sv
// Directed self-checking bench for axis_channel_serializer (16-bit inputs sign-extended to 32).
module tb_axis_channel_serializer;

`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic [15:0] s_data [6];
    logic [5:0]  s_valid;
    logic        enable;
    logic [5:0]  channel_mask;
    logic [31:0] decimation;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic        M_AXIS_tlast;
    logic        busy;
    logic [15:0] overrun_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] q[$];

    always #5 a_clk = ~a_clk;

    axis_channel_serializer #(
        .SAXIS_TDATA_WIDTH(16),
        .MAXIS_TDATA_WIDTH(32),
        .DECI_WIDTH       (32)
    ) dut (
        .a_clk          (a_clk),
        .a_resetn       (a_resetn),
        .S_AXIS_1_tdata (s_data[0]), .S_AXIS_1_tvalid(s_valid[0]),
        .S_AXIS_2_tdata (s_data[1]), .S_AXIS_2_tvalid(s_valid[1]),
        .S_AXIS_3_tdata (s_data[2]), .S_AXIS_3_tvalid(s_valid[2]),
        .S_AXIS_4_tdata (s_data[3]), .S_AXIS_4_tvalid(s_valid[3]),
        .S_AXIS_5_tdata (s_data[4]), .S_AXIS_5_tvalid(s_valid[4]),
        .S_AXIS_6_tdata (s_data[5]), .S_AXIS_6_tvalid(s_valid[5]),
        .enable         (enable),
        .channel_mask   (channel_mask),
        .decimation     (decimation),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tready  (M_AXIS_tready),
        .M_AXIS_tlast   (M_AXIS_tlast),
        .busy           (busy),
        .overrun_count  (overrun_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int ch);
        return (ch < 6) ? 32'(ch * 32'h11) : 32'hFFFF8066;
    endfunction

    // Accepted-word capture and stall-stability check.
    logic        stall_p = 1'b0;
    logic [33:0] prev_w;
    always @(negedge a_clk) begin
        if (!a_resetn) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) chk("stall_stable", {30'b0, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata}, {30'b0, prev_w});
            if (M_AXIS_tvalid && M_AXIS_tready) q.push_back({M_AXIS_tlast, M_AXIS_tdata});
            stall_p = M_AXIS_tvalid && !M_AXIS_tready;
            prev_w  = {M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata};
        end
    end

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    task automatic do_reset();
        a_resetn = 1'b0;
        #2;
        chk("rst_tvalid", M_AXIS_tvalid, 0);
        chk("rst_tlast", M_AXIS_tlast, 0);
        chk("rst_tdata", M_AXIS_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun_count, 0);
        step();
        a_resetn = 1'b1;
        step();
        q.delete();
    endtask

    task automatic load_holds();
        for (int k = 0; k < 6; k++) s_data[k] = (k < 5) ? 16'((k + 1) * 16'h11) : 16'h8066;
        s_valid = '1;
        step();
        s_valid = '0;
        for (int k = 0; k < 6; k++) s_data[k] = 16'hDEAD;
    endtask

    task automatic wait_q(input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            step();
            c++;
        end
        if (q.size() < n) chk("wait_q_timeout", q.size(), n);
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!M_AXIS_tvalid && c < budget) begin
            step();
            c++;
        end
        if (!M_AXIS_tvalid) chk("wait_valid_timeout", M_AXIS_tvalid, 1);
    endtask

    task automatic drain();
        int c = 0;
        while (busy && c < 100) begin
            step();
            c++;
        end
        if (busy) chk("drain_timeout", busy, 0);
        step();
    endtask

    // fid < 0: header frame_id not checked.
    task automatic check_frame(input string tag, input logic [5:0] m, input int fid);
        logic [32:0] ew[$];
        logic [32:0] em[$];
        logic [32:0] w;
        logic        last;
        if (HDR != 0) begin
            ew.push_back({1'b0, 16'(fid), 10'b0, m});
            em.push_back(fid < 0 ? 33'h1_0000_003F : '1);
        end
        for (int k = 0; k < 6; k++) begin
            if (m[k]) begin
                last = ((m >> (k + 1)) == 6'b0);
                ew.push_back({last, exp_data(k + 1)});
                em.push_back('1);
            end
        end
        for (int i = 0; i < ew.size(); i++) begin
            if (q.size() == 0) begin
                chk({tag, "_missing"}, q.size(), ew.size() - i);
                return;
            end
            w = q.pop_front();
            chk(tag, w & em[i], ew[i] & em[i]);
        end
    endtask

    initial begin
        int fw2;
        int fw6;
        int nvalid;
        fw2 = 2 + HDR;
        fw6 = 6 + HDR;
        a_resetn = 1'b0;
        enable = 1'b0; channel_mask = '0; decimation = 32'd4; M_AXIS_tready = 1'b0;
        s_valid = '0;
        for (int k = 0; k < 6; k++) s_data[k] = '0;
        do_reset();
        load_holds();

        // Frame emission, tick latency and period.
        decimation = 32'd4; channel_mask = 6'b000101; M_AXIS_tready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_pre_tick", M_AXIS_tvalid, 0);
        end
        step();
        chk("t1_tick_latency", M_AXIS_tvalid, 1);
        chk("t1_busy", busy, 1);
        repeat (4) step();
        chk("t1_period", M_AXIS_tvalid, 1);
        wait_q(2 * fw2, 50);
        enable = 1'b0;
        drain();
        check_frame("t1_frame0", 6'b000101, 0);
        check_frame("t1_frame1", 6'b000101, 1);
        chk("t1_leftover", q.size(), 0);

        // Backpressure with toggling tready.
        q.delete();
        decimation = 32'd100; channel_mask = 6'b111111; M_AXIS_tready = 1'b0; enable = 1'b1;
        for (int c = 0; c < 400 && q.size() < fw6; c++) begin
            step();
            M_AXIS_tready = ~M_AXIS_tready;
        end
        M_AXIS_tready = 1'b1; enable = 1'b0;
        drain();
        chk("t2_count", q.size(), fw6);
        check_frame("t2_frame", 6'b111111, 2);
        chk("t2_overrun", overrun_count, 0);

        // Overrun while stalled.
        q.delete();
        decimation = 32'd2; M_AXIS_tready = 1'b0; enable = 1'b1;
        repeat (20) step();
        chk("t3_overrun", overrun_count, 9);
        chk("t3_pending", M_AXIS_tvalid, 1);
        M_AXIS_tready = 1'b1; enable = 1'b0;
        drain();
        check_frame("t3_frame", 6'b111111, 3);
        chk("t3_overrun_hold", overrun_count, 9);

        // Empty mask: no output, no overrun.
        do_reset();
        load_holds();
        decimation = 32'd4; channel_mask = '0; enable = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (M_AXIS_tvalid) nvalid++;
        end
        chk("t4_mask0_valid", nvalid, 0);
        chk("t4_mask0_overrun", overrun_count, 0);
        enable = 1'b0;
        step();

        // decimation 0 behaves as 1.
        for (int d = 0; d < 2; d++) begin
            do_reset();
            load_holds();
            decimation = 32'(d); channel_mask = 6'b000001; M_AXIS_tready = 1'b1; enable = 1'b1;
            repeat (10) step();
            chk(d == 0 ? "t4_deci0_overrun" : "t4_deci1_overrun", overrun_count, 5 + HDR);
            enable = 1'b0;
            drain();
            chk(d == 0 ? "t4_deci0_words" : "t4_deci1_words", q.size(), 5 + 3 * HDR);
        end

        // Asynchronous reset during word 3, then clean restart.
        do_reset();
        load_holds();
        decimation = 32'd2; channel_mask = 6'b111111; M_AXIS_tready = 1'b1; enable = 1'b1;
        wait_valid(20);
        step();
        step();
        chk("t5_overrun_before", overrun_count, 1);
        enable = 1'b0;
        a_resetn = 1'b0;
        #2;
        chk("t5_rst_tvalid", M_AXIS_tvalid, 0);
        chk("t5_rst_overrun", overrun_count, 0);
        chk("t5_rst_busy", busy, 0);
        step();
        a_resetn = 1'b1;
        step();
        load_holds();
        q.delete();
        decimation = 32'd3; channel_mask = 6'b000101; enable = 1'b1;
        wait_q(fw2, 40);
        enable = 1'b0;
        drain();
        check_frame("t5_restart", 6'b000101, 0);
        chk("t5_leftover", q.size(), 0);

        // enable dropped mid-frame: frame completes, no further frames.
        q.delete();
        decimation = 32'd4; channel_mask = 6'b111111; enable = 1'b1;
        wait_valid(20);
        step();
        step();
        enable = 1'b0;
        drain();
        repeat (20) step();
        chk("t6_count", q.size(), fw6);
        check_frame("t6_frame", 6'b111111, 1);
        chk("t6_idle", M_AXIS_tvalid, 0);

`ifdef AXIS_CHANNEL_SERIALIZER_HEADER_EN
        // Header words with incrementing frame_id.
        do_reset();
        load_holds();
        decimation = 32'd5; channel_mask = 6'b000011; M_AXIS_tready = 1'b1; enable = 1'b1;
        wait_q(9, 60);
        enable = 1'b0;
        drain();
        check_frame("t7_hdr_f0", 6'b000011, 0);
        check_frame("t7_hdr_f1", 6'b000011, 1);
        check_frame("t7_hdr_f2", 6'b000011, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule
